// File: rtl/det4.sv
// Two-stage pipelined 4x4 determinant of signed 8-bit elements.
// Stage 1 registers the twelve 2x2 minors; stage 2 registers the wrapped result and the overflow flag.
module det4 (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [127:0] matrix,
    output logic signed [7:0]   det,
    output logic                ovf
);

    // |minor| <= 32640 fits 17 bits; the six-term sum needs 34, so 40 leaves margin.
    typedef logic signed [16:0] minor_t;
    typedef logic signed [39:0] wide_t;

    localparam wide_t DET_MAX = 40'sd127;
    localparam wide_t DET_MIN = -40'sd128;

    // Column pairs in the order 01, 02, 03, 12, 13, 23.
    localparam int COL_I [6] = '{0, 0, 0, 1, 1, 2};
    localparam int COL_J [6] = '{1, 2, 3, 2, 3, 3};

    logic signed [7:0] a [4][4];
    minor_t            m_d [6];
    minor_t            n_d [6];
    minor_t            m_q [6];
    minor_t            n_q [6];
    wide_t             det_full;
    logic              ovf_d;

    // p*s - q*r with operands widened first so no product is truncated.
    function automatic minor_t minor2(input logic signed [7:0] p, q, r, s);
        minor_t pe, qe, re, se;
        pe = minor_t'(p);
        qe = minor_t'(q);
        re = minor_t'(r);
        se = minor_t'(s);
        return pe * se - qe * re;
    endfunction

    function automatic wide_t wprod(input minor_t x, input minor_t y);
        wide_t xe, ye;
        xe = wide_t'(x);
        ye = wide_t'(y);
        return xe * ye;
    endfunction

    // NOTE: combinational blocks use blocking assignments and assign every output on every pass, so no latch is inferred.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a[r][c] = matrix[127 - 8 * (4 * r + c) -: 8];
            end
        end
        for (int k = 0; k < 6; k++) begin
            m_d[k] = minor2(a[0][COL_I[k]], a[0][COL_J[k]], a[1][COL_I[k]], a[1][COL_J[k]]);
            n_d[k] = minor2(a[2][COL_I[k]], a[2][COL_J[k]], a[3][COL_I[k]], a[3][COL_J[k]]);
        end
    end

    // Each rows-0/1 minor pairs with the complementary rows-2/3 minor (index 5-k).
    always_comb begin
        det_full = wprod(m_q[0], n_q[5]) - wprod(m_q[1], n_q[4]) + wprod(m_q[2], n_q[3])
                 + wprod(m_q[3], n_q[2]) - wprod(m_q[4], n_q[1]) + wprod(m_q[5], n_q[0]);
        ovf_d    = (det_full > DET_MAX) || (det_full < DET_MIN);
    end

    // NOTE: the minor arrays are pipeline registers, not a memory, so they are cleared on reset to flush in-flight results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 6; k++) begin
                m_q[k] <= '0;
                n_q[k] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            for (int k = 0; k < 6; k++) begin
                m_q[k] <= m_d[k];
                n_q[k] <= n_d[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det <= '0;
            ovf <= 1'b0;
        end else begin
            det <= det_full[7:0];
            ovf <= ovf_d;
        end
    end

endmodule

// File: tb/tb_det4.sv
// Self-checking bench for det4: directed cases plus random matrices checked against
// a Leibniz permutation-sum reference model, with expected results queued two cycles deep.
module tb_det4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic signed [127:0] matrix = '0;
    logic signed [7:0]   det;
    logic                ovf;

    det4 dut (
        .clk    (clk),
        .rst    (rst),
        .matrix (matrix),
        .det    (det),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] det;
        logic       ovf;
    } res_t;

    localparam logic [127:0] DIR0 = 128'h02030201_01020201_00040102_03050101;
    localparam logic [127:0] IDM  = 128'h01000000_00010000_00000100_00000001;
    localparam logic [127:0] IDN  = 128'hFF000000_00010000_00000100_00000001;
    localparam logic [127:0] SING = 128'h01020304_01020304_05060708_090A0B0C;
    localparam logic [127:0] D08  = 128'h08000000_00080000_00000800_00000008;
    localparam logic [127:0] D80  = 128'h80000000_00800000_00008000_00000080;
    localparam logic [7:0]   CORNERS [5] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01};

    res_t  exp_q [$];
    string tag_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        assert (got === want)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Determinant as the signed sum over all 24 permutations.
    function automatic longint ref_det(input logic [127:0] m);
        longint            e [4][4];
        longint            sum;
        longint            term;
        logic signed [7:0] b;
        int                p [4];
        int                inv;
        sum = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                b       = m[127 - 8 * (4 * r + c) -: 8];
                e[r][c] = longint'(b);
            end
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    for (int l = 0; l < 4; l++) begin
                        if (i != j && i != k && i != l && j != k && j != l && k != l) begin
                            p   = '{i, j, k, l};
                            inv = 0;
                            for (int x = 0; x < 4; x++)
                                for (int y = x + 1; y < 4; y++)
                                    if (p[x] > p[y]) inv++;
                            term = e[0][i] * e[1][j] * e[2][k] * e[3][l];
                            sum  = (inv % 2 == 1) ? sum - term : sum + term;
                        end
                    end
        return sum;
    endfunction

    function automatic res_t expect_of(input logic [127:0] m);
        longint d;
        res_t   r;
        d     = ref_det(m);
        r.det = d[7:0];
        r.ovf = (d > 127) || (d < -128);
        return r;
    endfunction

    function automatic logic [127:0] rand_matrix();
        logic [127:0] m;
        logic [7:0]   b;
        int           mode;
        mode = $urandom_range(0, 2);
        m    = '0;
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       b = 8'($urandom);
                1:       b = 8'($urandom_range(0, 6) - 3);
                default: b = CORNERS[$urandom_range(0, 4)];
            endcase
            m[127 - 8 * i -: 8] = b;
        end
        return m;
    endfunction

    // One cycle: check the result due now, then apply the next matrix and queue its expectation.
    task automatic cycle(input logic [127:0] m, input res_t want, input string tag);
        res_t  due;
        string due_tag;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            due     = '0;
            due_tag = "empty_queue";
        end else begin
            due     = exp_q.pop_front();
            due_tag = tag_q.pop_front();
        end
        check({due_tag, "/det"}, det, due.det);
        check({due_tag, "/ovf"}, {7'd0, ovf}, {7'd0, due.ovf});
        matrix = m;
        exp_q.push_back(want);
        tag_q.push_back(tag);
    endtask

    task automatic rand_cycle(input int idx);
        logic [127:0] m;
        m = rand_matrix();
        cycle(m, expect_of(m), $sformatf("rand%0d", idx));
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("por/det", det, 8'h00);
        check("por/ovf", {7'd0, ovf}, 8'h00);

        // Release on a negedge with DIR0 driven: one zero result, then DIR0's.
        @(negedge clk);
        @(negedge clk);
        matrix = DIR0;
        rst    = 1'b0;
        exp_q.push_back('{det: 8'h00, ovf: 1'b0}); tag_q.push_back("post_por_zero");
        exp_q.push_back('{det: 8'h01, ovf: 1'b0}); tag_q.push_back("dir0");

        cycle(IDM,  '{det: 8'h01, ovf: 1'b0}, "identity");
        cycle(IDN,  '{det: 8'hFF, ovf: 1'b0}, "identity_neg");
        cycle(SING, '{det: 8'h00, ovf: 1'b0}, "singular");
        cycle(D08,  '{det: 8'h00, ovf: 1'b1}, "diag08");
        cycle(D80,  '{det: 8'h00, ovf: 1'b1}, "diag80");
        cycle(IDM,  '{det: 8'h01, ovf: 1'b0}, "identity_a");
        cycle(IDM,  '{det: 8'h01, ovf: 1'b0}, "identity_b");
        cycle(IDM,  '{det: 8'h01, ovf: 1'b0}, "identity_c");

        // Mid-operation reset between edges while det = 1 is showing.
        #2 rst = 1'b1;
        #1;
        check("midrst/det", det, 8'h00);
        check("midrst/ovf", {7'd0, ovf}, 8'h00);
        exp_q.delete();
        tag_q.delete();
        @(negedge clk);
        check("midrst_hold/det", det, 8'h00);
        check("midrst_hold/ovf", {7'd0, ovf}, 8'h00);
        matrix = IDN;
        rst    = 1'b0;
        exp_q.push_back('{det: 8'h00, ovf: 1'b0}); tag_q.push_back("post_rst_zero");
        exp_q.push_back('{det: 8'hFF, ovf: 1'b0}); tag_q.push_back("post_rst_idn");

        cycle(DIR0, '{det: 8'h01, ovf: 1'b0}, "dir0_again");
        cycle(D80,  '{det: 8'h00, ovf: 1'b1}, "diag80_again");

        for (int i = 0; i < 300; i++) rand_cycle(i);

        cycle('0, '{det: 8'h00, ovf: 1'b0}, "flush0");
        cycle('0, '{det: 8'h00, ovf: 1'b0}, "flush1");
        cycle('0, '{det: 8'h00, ovf: 1'b0}, "flush2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/det4.md
DET4 -- requirements
Module: det4

Interface
REQ-001 clk  input  1  — single system clock; all state updates on its rising edge.
REQ-002 rst  input  1  — asynchronous, active-high reset; clears all pipeline and output registers immediately.
REQ-003 matrix  input  128 signed — 4x4 matrix of 16 signed 8-bit two's-complement elements.
  - Packed row-major, MSB first: element (r,c) at bits [127-8*(4r+c) -: 8].
  - Element (0,0) = matrix[127:120]; element (3,3) = matrix[7:0].
REQ-004 det  output  8 signed — determinant, low 8 bits of the exact two's-complement result.
REQ-005 ovf  output  1  — high when the exact determinant lies outside [-128, 127].

Function
REQ-006 Compute the exact determinant internally, at full precision.
  - Intermediates: signed, at least 34 bits (|det| <= 24*128^4 < 2^33).
  - No intermediate truncation or overflow.
REQ-007 Method: Laplace / 2x2-minor expansion.
  - Six 2x2 minors of rows 0-1: m_ij = a0i*a1j - a0j*a1i.
  - Six 2x2 minors of rows 2-3: n_ij.
  - det = m01*n23 - m02*n13 + m03*n12 + m12*n03 - m13*n02 + m23*n01.
REQ-008 Pipeline: two register stages, free-running every clk edge; no enable or handshake.
  - Stage 1: register the twelve 2x2 minors computed from the current matrix input.
  - Stage 2: register det and ovf computed from the stage-1 minors.
REQ-009 Latency: exactly 2 clk rising edges from matrix sampling to det/ovf update.
  - Throughput: one new matrix per cycle.
  - Outputs hold between edges.
REQ-010 det = bits [7:0] of the full-precision result (wrap, no saturation).
REQ-011 ovf = 1 iff full result > 127 or < -128; otherwise 0.
  - Computed from the full-precision value, not from det.
REQ-012 Signed elements, signed multiplies throughout.
  - 0x80 = -128; 0xFF = -1.
REQ-013 Unknown/X matrix input is not required to produce defined outputs.
  - Outputs become defined 2 cycles after a valid input is applied.

Reset
REQ-014 While rst = 1: stage-1 minors = 0, det = 8'h00, ovf = 0.
  - Takes effect asynchronously, without waiting for a clk edge.
REQ-015 Reset mid-operation discards all in-flight results.
  - After rst falls, det/ovf reflect a matrix only once two rising edges have sampled it.
  - Until then they read 0 / 0, since zeroed minors give det 0 and ovf 0.
REQ-016 Deassertion of rst is synchronous to the design.
  - The first rising edge with rst = 0 samples matrix into stage 1.

Verification
REQ-017 Directed cases; each check taken 2 edges after applying matrix, with rst low.
  - matrix = {02,03,02,01, 01,02,02,01, 00,04,01,02, 03,05,01,01} (rows 0..3) -> det = 8'h01 (1), ovf = 0.
  - Identity (diag 01,01,01,01, others 00) -> det = 1, ovf = 0. Same matrix with diagonal (FF,01,01,01) -> det = 8'hFF (-1), ovf = 0.
  - Singular matrix (row 1 = row 0, e.g. both 01,02,03,04) -> det = 0, ovf = 0.
  - diag(08,08,08,08) -> exact 4096 -> det = 8'h00, ovf = 1. diag(80,80,80,80) -> exact 2^28 -> det = 8'h00, ovf = 1.
  - Reset: assert rst asynchronously between edges while nonzero outputs are present -> det = 0, ovf = 0 immediately.
    - Release rst -> outputs stay 0 for one edge, then show the correct result on the second edge.
  - Back-to-back: apply a different matrix on each consecutive cycle -> each result appears exactly 2 cycles later, in order, with no bubbles.
